fpflt_seq: RTL and testbench

FPFLT_SEQ -- requirements
Module: fpflt_seq

---
 rtl/fpflt_seq.sv | 121 ++++++++++++
 tb/tb_fpflt_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpflt_seq.sv
// fpflt_seq: queues integer operands and sequences them one at a time
// through an external int-to-float converter, holding each result.
// Ports: in_* operand push, fp_* converter handshake, out_* result
// hold/accept, sticky/clr_sticky accumulated flags, busy activity.
// Define FPFLT_SEQ_STICKY_EN to enable sticky flag accumulation.
module fpflt_seq #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        fp_run,
  output logic [31:0] fp_x,
  input  logic        fp_stall,
  input  logic [31:0] fp_z,
  input  logic [4:0]  fp_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_z,
  output logic [4:0]  out_flags,
  output logic [4:0]  sticky,
  input  logic        clr_sticky,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, RUN} state_e;

  state_e          state_q, state_d;
  logic [31:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q;
  logic [31:0]     out_z_q;
  logic [4:0]      out_flags_q;
  logic            push, pop;

  // in_ready is forced low while reset is held
  assign in_ready = rst_n & (count_q < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  // a capture always pops the head that was being converted
  assign pop      = (state_q == RUN) & ~fp_stall;

  assign fp_run    = (state_q == RUN);
  assign fp_x      = (count_q != '0) ? mem_q[rd_ptr_q] : 32'h0;
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_flags = out_flags_q;
  assign busy      = fp_run | (count_q != '0) | out_valid_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if ((count_q != '0) && !out_valid_q) state_d = RUN;
      RUN:  if (!fp_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_flags_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (pop) begin
        out_valid_q <= 1'b1;
        out_z_q     <= fp_z;
        out_flags_q <= fp_flags;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // storage needs no reset; count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

`ifdef FPFLT_SEQ_STICKY_EN
  logic [4:0] sticky_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (clr_sticky ? 5'b0 : sticky_q)
                | (pop ? fp_flags : 5'b0);
    end
  end

  assign sticky = sticky_q;
`else
  logic unused_clr;
  assign unused_clr = clr_sticky;
  assign sticky     = 5'b0;
`endif

endmodule

// File: tb/tb_fpflt_seq.sv
// tb_fpflt_seq: directed and random stimulus for fpflt_seq, checked
// against an in-order scoreboard and a stub converter model.
module tb_fpflt_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        fp_run;
  logic [31:0] fp_x;
  logic        fp_stall;
  logic [31:0] fp_z;
  logic [4:0]  fp_flags;
  logic        out_valid, out_ready;
  logic [31:0] out_z;
  logic [4:0]  out_flags;
  logic [4:0]  sticky;
  logic        clr_sticky;
  logic        busy;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] exp_q[$];
  logic [4:0]  s_m = 5'b0;

  fpflt_seq #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .fp_run(fp_run), .fp_x(fp_x), .fp_stall(fp_stall),
    .fp_z(fp_z), .fp_flags(fp_flags),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_flags(out_flags),
    .sticky(sticky), .clr_sticky(clr_sticky), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] conv(input logic [31:0] x);
    if (x == 32'd1) return 32'h3F800000;
    return {x[7:0], x[31:8]} ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [4:0] flg(input logic [31:0] x);
    return x[4:0] ^ x[9:5];
  endfunction

  assign fp_z     = conv(fp_x);
  assign fp_flags = flg(fp_x);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: items pushed and not yet consumed, oldest first
  always @(posedge clk) begin
    if (rst_n) begin
      int fcnt;
      logic [31:0] d;
      fcnt = exp_q.size() - (out_valid ? 1 : 0);
      chk("busy", 32'(busy), 32'(exp_q.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(fcnt < 4));
      chk("sticky", 32'(sticky), 32'(s_m));
      if (fp_run) begin
        if (exp_q.size() == 0) chk("run_empty", 32'(fp_run), 0);
        else chk("fp_x", fp_x, exp_q[0]);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(out_valid), 0);
        end else begin
          d = exp_q.pop_front();
          chk("out_z", out_z, conv(d));
          chk("out_flags", 32'(out_flags), 32'(flg(d)));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
`ifdef FPFLT_SEQ_STICKY_EN
      if (clr_sticky) s_m = 5'b0;
      if (fp_run && !fp_stall) s_m = s_m | fp_flags;
`endif
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 50) begin
      step;
      n++;
    end
    chk("push_wait", 32'(in_ready), 1);
    step;
  endtask

  task automatic drain;
    int n;
    in_valid  = 1'b0;
    fp_stall  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (busy && n < 200) begin
      step;
      n++;
    end
    chk("drain_busy", 32'(busy), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    fp_stall = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_fp_run", 32'(fp_run), 0);
    chk("rst_out_z", out_z, 0);
    chk("rst_sticky", 32'(sticky), 0);
    step; step;
    rst_n = 1'b1;
    step;
    chk("resume_ready", 32'(in_ready), 1);

    // single operand, no stall: result after two edges
    push_one(32'd1);
    in_valid = 1'b0;
    chk("t1_run_k", 32'(fp_run), 0);
    chk("t1_busy_k", 32'(busy), 1);
    step;
    chk("t1_run_k1", 32'(fp_run), 1);
    chk("t1_fp_x", fp_x, 32'd1);
    chk("t1_ov_k1", 32'(out_valid), 0);
    step;
    chk("t1_ov_k2", 32'(out_valid), 1);
    chk("t1_out_z", out_z, 32'h3F800000);
    chk("t1_run_k2", 32'(fp_run), 0);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("t1_ov_clr", 32'(out_valid), 0);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_z_hold", out_z, 32'h3F800000);

    // three stall cycles in RUN
    push_one(32'h12345678);
    in_valid = 1'b0;
    step;
    chk("t2_run", 32'(fp_run), 1);
    fp_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("t2_hold_run", 32'(fp_run), 1);
      chk("t2_hold_x", fp_x, 32'h12345678);
      chk("t2_hold_ov", 32'(out_valid), 0);
    end
    fp_stall = 1'b0;
    step;
    chk("t2_ov", 32'(out_valid), 1);
    chk("t2_z", out_z, conv(32'h12345678));
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("t2_single_pop", 32'(busy), 0);

    // fill with result unconsumed, then offer one more
    for (int i = 0; i < 5; i++) push_one(32'hA0000000 + i);
    chk("t3_full", 32'(in_ready), 0);
    in_data = 32'hBEEF0000;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("t3_held_off", 32'(in_ready), 0);
      chk("t3_no_issue", 32'(fp_run), 0);
      chk("t3_first_z", out_z, conv(32'hA0000000));
    end
    drain;

    // eight streamed operands, pointers wrap twice
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_one(32'h00C00000 + 32'(i * 3));
    drain;

    // sticky accumulation and clear-with-capture
    out_ready = 1'b1;
    push_one(32'd1);
    push_one(32'd16);
    drain;
`ifdef FPFLT_SEQ_STICKY_EN
    chk("t5_sticky", 32'(sticky), 32'h11);
`else
    chk("t5_sticky", 32'(sticky), 0);
`endif
    push_one(32'd4);
    in_valid = 1'b0;
    step;
    clr_sticky = 1'b1;
    step;
    clr_sticky = 1'b0;
`ifdef FPFLT_SEQ_STICKY_EN
    chk("t5_clr", 32'(sticky), 32'h04);
`else
    chk("t5_clr", 32'(sticky), 0);
`endif
    drain;

    // reset while RUN is stalled with operands queued
    fp_stall = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(32'h7000 + i);
    in_valid = 1'b0;
    chk("t6_pre_run", 32'(fp_run), 1);
    rst_n = 1'b0;
    #1;
    chk("t6_run", 32'(fp_run), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ov", 32'(out_valid), 0);
    chk("t6_ready", 32'(in_ready), 0);
    chk("t6_fp_x", fp_x, 0);
    exp_q.delete();
    s_m = 5'b0;
    fp_stall = 1'b0;
    step; step;
    rst_n = 1'b1;
    step;
    chk("t6_resume", 32'(in_ready), 1);
    for (int i = 0; i < 5; i++) begin
      step;
      chk("t6_no_result", 32'(out_valid), 0);
      chk("t6_no_run", 32'(fp_run), 0);
    end

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = ($urandom_range(0, 7) == 0) ? 32'd1 : $urandom;
      out_ready  = ($urandom_range(0, 2) != 0);
      fp_stall   = ($urandom_range(0, 3) == 0);
      clr_sticky = ($urandom_range(0, 15) == 0);
      step;
    end
    clr_sticky = 1'b0;
    drain;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
